// File: rtl/l2_req_arb.sv
// l2_req_arb: round-robin arbiter sharing the host read-request port among the L2 channels and
// routing host responses back by stream ID. Define L2_REQ_ARB_CREDIT_EN for per-channel credits and o_err.
module l2_req_arb #(
    parameter int addr_width = 64,
    parameter int nstrms     = 64,
    parameter int l2_nstrms  = 16,
    parameter int channels   = nstrms / l2_nstrms,
    parameter int max_out    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [channels-1:0]            i_req_v,
    output logic [channels-1:0]            i_req_r,
    input  logic [channels*$clog2(nstrms)-1:0] i_req_sid,
    input  logic [channels*addr_width-1:0] i_req_ea,
    output logic                           o_req_v,
    input  logic                           o_req_r,
    output logic [$clog2(nstrms)-1:0]      o_req_sid,
    output logic [addr_width-1:0]          o_req_ea,
    input  logic                           i_rsp_v,
    output logic                           i_rsp_r,
    input  logic [$clog2(nstrms)-1:0]      i_rsp_sid,
    output logic [channels-1:0]            o_rsp_v,
    input  logic [channels-1:0]            o_rsp_r,
    output logic [channels*$clog2(nstrms)-1:0] o_rsp_sid,
    output logic                           o_err
);

    localparam int nstrms_width    = $clog2(nstrms);
    localparam int l2_nstrms_width = $clog2(l2_nstrms);
    localparam int ch_width        = nstrms_width - l2_nstrms_width;

    // The channel field of a stream ID must address exactly the set of channels.
    if (channels != (1 << ch_width)) begin : g_bad_channels
        $error("l2_req_arb: channels must equal nstrms/l2_nstrms and be a power of two");
    end
    if (max_out < 1) begin : g_bad_max_out
        $error("l2_req_arb: max_out must be at least 1");
    end

    logic [channels-1:0] eligible;
    logic                load_en;
    logic                grant_any;
    logic [ch_width-1:0] grant_ch;
    logic [ch_width-1:0] rr_ptr;
    logic [ch_width-1:0] rsp_ch;
    logic                rsp_acc;
    logic [channels-1:0] rsp_take;

    assign load_en = !o_req_v || o_req_r;

    // Scan from rr_ptr upward; the index wraps naturally because channels is a power of two.
    always_comb begin
        grant_any = 1'b0;
        grant_ch  = '0;
        for (int i = 0; i < channels; i++) begin
            if (!grant_any && eligible[rr_ptr + ch_width'(i)]) begin
                grant_any = 1'b1;
                grant_ch  = rr_ptr + ch_width'(i);
            end
        end
    end

    always_comb begin
        i_req_r = '0;
        if (!reset && load_en && grant_any) begin
            i_req_r[grant_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_req_v   <= 1'b0;
            o_req_sid <= '0;
            o_req_ea  <= '0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            o_req_v <= grant_any;
            if (grant_any) begin
                o_req_sid <= i_req_sid[grant_ch*nstrms_width +: nstrms_width];
                o_req_ea  <= i_req_ea[grant_ch*addr_width +: addr_width];
                rr_ptr    <= grant_ch + ch_width'(1);
            end
        end
    end

    // Response readiness depends only on the target channel's output register, never on o_req_r.
    assign rsp_ch   = i_rsp_sid[nstrms_width-1:l2_nstrms_width];
    assign i_rsp_r  = !o_rsp_v[rsp_ch] || o_rsp_r[rsp_ch];
    assign rsp_acc  = i_rsp_v && i_rsp_r;
    assign rsp_take = o_rsp_v & o_rsp_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            o_rsp_v   <= '0;
            o_rsp_sid <= '0;
        end else begin
            for (int c = 0; c < channels; c++) begin
                if (rsp_acc && rsp_ch == ch_width'(c)) begin
                    o_rsp_v[c]                                 <= 1'b1;
                    o_rsp_sid[c*nstrms_width +: nstrms_width] <= i_rsp_sid;
                end else if (rsp_take[c]) begin
                    o_rsp_v[c] <= 1'b0;
                end
            end
        end
    end

`ifdef L2_REQ_ARB_CREDIT_EN
    localparam int cnt_width = $clog2(max_out + 1);

    logic [cnt_width-1:0] cnt [channels];

    always_comb begin
        eligible = '0;
        for (int c = 0; c < channels; c++) begin
            eligible[c] = i_req_v[c] && (cnt[c] < cnt_width'(max_out));
        end
    end

    // A credit returns when the response leaves toward the channel, not when the host delivers it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < channels; c++) begin
                cnt[c] <= '0;
            end
            o_err <= 1'b0;
        end else begin
            for (int c = 0; c < channels; c++) begin
                if (i_req_r[c] && !rsp_take[c]) begin
                    cnt[c] <= cnt[c] + 1'b1;
                end else if (!i_req_r[c] && rsp_take[c] && cnt[c] != '0) begin
                    cnt[c] <= cnt[c] - 1'b1;
                end
            end
            if (rsp_acc && cnt[rsp_ch] == '0) begin
                o_err <= 1'b1;
            end
        end
    end
`else
    assign eligible = i_req_v;
    assign o_err    = 1'b0;
`endif

endmodule

// File: tb/tb_l2_req_arb.sv
// tb_l2_req_arb: table vectors, directed corner sequences and a random phase, checked against a
// reference model with request/response scoreboards.
module tb_l2_req_arb;

    localparam int AW = 64;
    localparam int NW = 6;
    localparam int CH = 4;
`ifdef L2_REQ_ARB_CREDIT_EN
    localparam bit CREDIT = 1'b1;
`else
    localparam bit CREDIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] i_req_v, i_req_r;
    logic [CH*NW-1:0] i_req_sid;
    logic [CH*AW-1:0] i_req_ea;
    logic          o_req_v, o_req_r;
    logic [NW-1:0] o_req_sid;
    logic [AW-1:0] o_req_ea;
    logic          i_rsp_v, i_rsp_r;
    logic [NW-1:0] i_rsp_sid;
    logic [CH-1:0] o_rsp_v, o_rsp_r;
    logic [CH*NW-1:0] o_rsp_sid;
    logic          o_err;

    always #5 clk = ~clk;

    l2_req_arb dut (
        .clk       (clk),
        .reset     (reset),
        .i_req_v   (i_req_v),
        .i_req_r   (i_req_r),
        .i_req_sid (i_req_sid),
        .i_req_ea  (i_req_ea),
        .o_req_v   (o_req_v),
        .o_req_r   (o_req_r),
        .o_req_sid (o_req_sid),
        .o_req_ea  (o_req_ea),
        .i_rsp_v   (i_rsp_v),
        .i_rsp_r   (i_rsp_r),
        .i_rsp_sid (i_rsp_sid),
        .o_rsp_v   (o_rsp_v),
        .o_rsp_r   (o_rsp_r),
        .o_rsp_sid (o_rsp_sid),
        .o_err     (o_err)
    );

    typedef struct packed {
        logic [NW-1:0] sid;
        logic [AW-1:0] ea;
    } req_t;

    typedef struct {
        logic [CH-1:0] req_v;
        logic          oreq_r;
        logic [CH-1:0] exp_req_r;
        logic          exp_ov;
        int            exp_och;
    } vec_t;

    // Reference model state.
    int            m_rr;
    logic          m_req_v;
    logic [CH-1:0] m_rsp_v;
    int            m_cnt [CH];
    logic          m_err;
    logic          m_gany;
    int            m_gch;
    logic [CH-1:0] exp_req_r;
    logic          exp_rsp_r;
    req_t          req_q [$];
    logic [NW-1:0] rsp_q [CH][$];

    int n_checks = 0;
    int n_fail   = 0;
    int grants1  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_comb();
        int c;
        logic [1:0] rch;
        m_gany = 1'b0;
        m_gch  = 0;
        for (int d = 0; d < CH; d++) begin
            c = (m_rr + d) % CH;
            if (!m_gany && i_req_v[c] && (!CREDIT || m_cnt[c] < 8)) begin
                m_gany = 1'b1;
                m_gch  = c;
            end
        end
        exp_req_r = '0;
        if (!reset && (!m_req_v || o_req_r) && m_gany) exp_req_r[m_gch] = 1'b1;
        rch = i_rsp_sid[5:4];
        exp_rsp_r = !m_rsp_v[rch] || o_rsp_r[rch];
    endtask

    task automatic model_update();
        logic [1:0] rch;
        logic       acc, take, give;
        if (reset) begin
            m_rr = 0; m_req_v = 1'b0; m_rsp_v = '0; m_err = 1'b0;
            req_q.delete();
            for (int c = 0; c < CH; c++) begin
                m_cnt[c] = 0;
                rsp_q[c].delete();
            end
            return;
        end
        rch = i_rsp_sid[5:4];
        acc = i_rsp_v && exp_rsp_r;
        if (CREDIT && acc && m_cnt[rch] == 0) m_err = 1'b1;
        for (int c = 0; c < CH; c++) begin
            take = m_rsp_v[c] && o_rsp_r[c];
            give = exp_req_r[c];
            if (CREDIT && give && !take) m_cnt[c]++;
            else if (CREDIT && take && !give && m_cnt[c] > 0) m_cnt[c]--;
            if (take) m_rsp_v[c] = 1'b0;
        end
        if (acc) begin
            m_rsp_v[rch] = 1'b1;
            rsp_q[rch].push_back(i_rsp_sid);
        end
        if (!m_req_v || o_req_r) begin
            m_req_v = m_gany;
            if (m_gany) begin
                req_q.push_back({i_req_sid[m_gch*NW +: NW], i_req_ea[m_gch*AW +: AW]});
                m_rr = (m_gch + 1) % CH;
            end
        end
    endtask

    task automatic applyStimulus(input logic [CH-1:0] req_v, input logic oreq_r, input logic rsp_v,
                                 input logic [NW-1:0] rsp_sid, input logic [CH-1:0] orsp_r);
        i_req_v   = req_v;
        o_req_r   = oreq_r;
        i_rsp_v   = rsp_v;
        i_rsp_sid = rsp_sid;
        o_rsp_r   = orsp_r;
        @(negedge clk);
    endtask

    // Compares against the model at the negedge, then advances the model and the clock.
    task automatic checkOutput();
        req_t r;
        logic [NW-1:0] s;
        model_comb();
        check("i_req_r", 64'(i_req_r), 64'(exp_req_r));
        check("i_rsp_r", 64'(i_rsp_r), 64'(exp_rsp_r));
        check("o_req_v", 64'(o_req_v), 64'(m_req_v));
        check("o_rsp_v", 64'(o_rsp_v), 64'(m_rsp_v));
        check("o_err", 64'(o_err), 64'(m_err));
        if (i_req_r[1]) grants1++;
        if (o_req_v && o_req_r) begin
            if (req_q.size() == 0) begin
                check("req_sb_nonempty", 64'(0), 64'(1));
            end else begin
                r = req_q.pop_front();
                check("o_req_sid", 64'(o_req_sid), 64'(r.sid));
                check("o_req_ea", o_req_ea, r.ea);
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (o_rsp_v[c] && o_rsp_r[c]) begin
                if (rsp_q[c].size() == 0) begin
                    check("rsp_sb_nonempty", 64'(0), 64'(1));
                end else begin
                    s = rsp_q[c].pop_front();
                    check("o_rsp_sid", 64'(o_rsp_sid[c*NW +: NW]), 64'(s));
                end
            end
        end
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [NW-1:0] sid, input logic [AW-1:0] ea);
        i_req_sid[c*NW +: NW] = sid;
        i_req_ea[c*AW +: AW]  = ea;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        applyStimulus('0, 1'b1, 1'b0, '0, '0);
        checkOutput();
        reset = 1'b0;
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{4'hF, 1'b1, 4'b0001, 1'b0, 0};
        vecs[1] = '{4'hF, 1'b1, 4'b0010, 1'b1, 0};
        vecs[2] = '{4'hF, 1'b1, 4'b0100, 1'b1, 1};
        vecs[3] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2};
        vecs[4] = '{4'hF, 1'b1, 4'b0001, 1'b1, 3};
        vecs[5] = '{4'hF, 1'b1, 4'b0010, 1'b1, 0};

        m_rr = 0; m_req_v = 1'b0; m_rsp_v = '0; m_err = 1'b0;
        for (int c = 0; c < CH; c++) m_cnt[c] = 0;
        reset = 1'b1;
        i_req_v = '0; o_req_r = 1'b0; i_rsp_v = 1'b0; i_rsp_sid = '0; o_rsp_r = '0;
        i_req_sid = '0; i_req_ea = '0;
        repeat (2) @(posedge clk);
        #1;

        // Requests during reset must not be granted.
        for (int c = 0; c < CH; c++) set_req(c, NW'(c*16 + 3), 64'(c) << 8);
        applyStimulus(4'hF, 1'b1, 1'b0, '0, '0);
        check("reset_req_r", 64'(i_req_r), 64'(0));
        checkOutput();
        reset = 1'b0;
        applyStimulus('0, 1'b1, 1'b0, '0, '0);
        check("reset_o_req_sid", 64'(o_req_sid), 64'(0));
        check("reset_o_req_ea", o_req_ea, 64'(0));
        check("reset_o_rsp_sid", 64'(o_rsp_sid), 64'(0));
        checkOutput();

        // Round-robin order with all channels requesting.
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < CH; c++) set_req(c, NW'(c*16 + i), {$urandom, $urandom});
            applyStimulus(vecs[i].req_v, vecs[i].oreq_r, 1'b0, '0, '0);
            check("rr_req_r", 64'(i_req_r), 64'(vecs[i].exp_req_r));
            check("rr_o_req_v", 64'(o_req_v), 64'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) check("rr_o_req_ch", 64'(o_req_sid[5:4]), 64'(vecs[i].exp_och));
            checkOutput();
        end
        repeat (2) begin
            applyStimulus('0, 1'b1, 1'b0, '0, '0);
            checkOutput();
        end

        // Single requester stalled by the host.
        set_req(2, 6'd33, 64'h80);
        applyStimulus(4'b0100, 1'b0, 1'b0, '0, '0);
        check("stall_first_grant", 64'(i_req_r), 64'b0100);
        checkOutput();
        repeat (3) begin
            applyStimulus(4'b0100, 1'b0, 1'b0, '0, '0);
            check("stall_o_req_v", 64'(o_req_v), 64'(1));
            check("stall_sid", 64'(o_req_sid), 64'd33);
            check("stall_ea", o_req_ea, 64'h80);
            check("stall_no_grant", 64'(i_req_r), 64'(0));
            checkOutput();
        end
        applyStimulus(4'b0100, 1'b1, 1'b0, '0, '0);
        check("stall_release_grant", 64'(i_req_r), 64'b0100);
        checkOutput();
        repeat (2) begin
            applyStimulus('0, 1'b1, 1'b0, '0, '0);
            checkOutput();
        end

        // Channel 1 hammers with no responses; credit build caps at 8.
        do_reset();
        grants1 = 0;
        for (int i = 0; i < 10; i++) begin
            set_req(1, NW'(16 + i), {$urandom, $urandom});
            applyStimulus(4'b0010, 1'b1, 1'b0, '0, '0);
            checkOutput();
        end
        check("ch1_grant_count", 64'(grants1), CREDIT ? 64'd8 : 64'd10);

        // Response backpressure on channel 1, then one credit returned.
        grants1 = 0;
        applyStimulus(4'b0010, 1'b1, 1'b1, 6'd17, 4'b0000);
        check("rsp17_accept", 64'(i_rsp_r), 64'(1));
        checkOutput();
        repeat (2) begin
            applyStimulus(4'b0010, 1'b1, 1'b1, 6'd20, 4'b0000);
            check("rsp_held_v", 64'(o_rsp_v[1]), 64'(1));
            check("rsp_held_sid", 64'(o_rsp_sid[1*NW +: NW]), 64'd17);
            check("rsp20_blocked", 64'(i_rsp_r), 64'(0));
            checkOutput();
        end
        applyStimulus(4'b0010, 1'b1, 1'b1, 6'd20, 4'b0010);
        check("rsp20_accept", 64'(i_rsp_r), 64'(1));
        checkOutput();
        applyStimulus(4'b0010, 1'b1, 1'b0, '0, 4'b0000);
        check("rsp20_valid", 64'(o_rsp_v[1]), 64'(1));
        check("rsp20_sid", 64'(o_rsp_sid[1*NW +: NW]), 64'd20);
        checkOutput();
        repeat (2) begin
            applyStimulus(4'b0010, 1'b1, 1'b0, '0, 4'b0000);
            checkOutput();
        end
        check("ch1_regrant_count", 64'(grants1), CREDIT ? 64'd1 : 64'd7);
        applyStimulus('0, 1'b1, 1'b0, '0, 4'b0010);
        checkOutput();

        // Unsolicited response on channel 2.
        do_reset();
        applyStimulus('0, 1'b1, 1'b1, 6'd40, 4'b0100);
        checkOutput();
        applyStimulus('0, 1'b1, 1'b0, '0, 4'b0000);
        check("rsp40_valid", 64'(o_rsp_v[2]), 64'(1));
        check("rsp40_sid", 64'(o_rsp_sid[2*NW +: NW]), 64'd40);
        check("rsp40_err", 64'(o_err), 64'(CREDIT));
        checkOutput();
        repeat (3) begin
            applyStimulus('0, 1'b1, 1'b0, '0, 4'b0100);
            check("err_sticky", 64'(o_err), 64'(CREDIT));
            checkOutput();
        end

        // Reset with request and response entries in flight.
        applyStimulus(4'hF, 1'b0, 1'b1, 6'd5, 4'b0000);
        checkOutput();
        applyStimulus(4'hF, 1'b0, 1'b0, '0, 4'b0000);
        check("inflight_req_v", 64'(o_req_v), 64'(1));
        check("inflight_rsp_v", 64'(o_rsp_v), 64'b0001);
        checkOutput();
        reset = 1'b1;
        applyStimulus(4'hF, 1'b0, 1'b0, '0, 4'b0000);
        check("midreset_req_r", 64'(i_req_r), 64'(0));
        checkOutput();
        reset = 1'b0;
        applyStimulus(4'hF, 1'b1, 1'b0, '0, 4'b0000);
        check("post_reset_req_v", 64'(o_req_v), 64'(0));
        check("post_reset_rsp_v", 64'(o_rsp_v), 64'(0));
        check("post_reset_err", 64'(o_err), 64'(0));
        check("post_reset_rr", 64'(i_req_r), 64'b0001);
        checkOutput();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < CH; c++) set_req(c, NW'($urandom_range(63)), {$urandom, $urandom});
            applyStimulus(CH'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                          NW'($urandom_range(63)), CH'($urandom_range(15)));
            checkOutput();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_req_arb.md
# l2_req_arb

Round-robin arbiter that shares the single OpenCAPI 3.0 host read-request port among the `channels` L2 stream-controller channels (each serving `l2_nstrms` streams). It tracks outstanding requests per channel with credit counters and routes each host response back to the owning channel by stream ID. It sits between the per-channel L2 controllers and the host request/response interfaces.

## Interface
- `addr_width`, 64, host effective-address width in bits
- `nstrms`, 64, total streams; `nstrms_width` = $clog2(nstrms)
- `l2_nstrms`, 16, streams per channel; `l2_nstrms_width` = $clog2(l2_nstrms)
- `channels`, nstrms/l2_nstrms (4), number of requesting channels
- `max_out`, 8, maximum outstanding requests per channel; `cnt_width` = $clog2(max_out+1)

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `reset` in 1: synchronous, active-high
- `i_req_v` in channels: per-channel request valid
- `i_req_r` out channels: per-channel request ready (grant)
- `i_req_sid` in channels*nstrms_width: per-channel stream ID, channel c at [c*nstrms_width +: nstrms_width]
- `i_req_ea` in channels*addr_width: per-channel effective address, same packing
- `o_req_v` out 1, `o_req_r` in 1, `o_req_sid` out nstrms_width, `o_req_ea` out addr_width: host request
- `i_rsp_v` in 1, `i_rsp_r` out 1, `i_rsp_sid` in nstrms_width: host response
- `o_rsp_v` out channels, `o_rsp_r` in channels, `o_rsp_sid` out channels*nstrms_width: routed responses
- `o_err` out 1: sticky protocol error

## Operation
- Channel of a stream ID: ch = sid[nstrms_width-1:l2_nstrms_width].
- Eligible(c) = i_req_v[c] && cnt[c] < max_out (credit term only with macro, see Configuration).
- Request output register: one entry. Load enable = !o_req_v || o_req_r. When enabled and any channel eligible, grant the first eligible channel at or after `rr_ptr` (wrapping); i_req_r[c] = 1 only for that channel in that cycle; register loads its sid/ea; rr_ptr <= granted+1 mod channels. No grant -> rr_ptr unchanged.
- Credit counters: +1 on grant to c, -1 on response handed to channel c (o_rsp_v[c] && o_rsp_r[c]); both same cycle -> unchanged. Never exceed max_out; never go below 0.
- Response path: one-entry register per channel. i_rsp_r = !o_rsp_v[ch] || o_rsp_r[ch] for ch of i_rsp_sid. On accept, o_rsp_v[ch] <= 1, o_rsp_sid[ch] <= i_rsp_sid.
- Response accepted for channel with cnt == 0 (macro on): response still routed, counter held at 0, o_err set and held until reset.
- Requester sid whose channel field differs from requesting channel: forwarded unchanged (not checked).

## Timing
- Reset values: o_req_v 0, o_req_sid 0, o_req_ea 0, o_rsp_v all 0, o_rsp_sid all 0, o_err 0, i_req_r all 0 while reset high, all cnt 0, rr_ptr 0.
- Request latency: grant in cycle N -> o_req_v high cycle N+1. Full throughput: one grant per cycle while o_req_r held high.
- Response latency: accept in cycle N -> o_rsp_v[ch] high cycle N+1; one response per cycle.
- o_req_* and o_rsp_* remain stable while valid and not ready.
- Reset mid-operation drops in-flight register contents and clears all credits; requesters must reissue.
- i_req_r and i_rsp_r are combinational from registered state and current valids/readies; no combinational path from o_req_r to i_rsp_r.

## Configuration
- `L2_REQ_ARB_CREDIT_EN` defined: credit counters, max_out limit and o_err implemented as above.
- Not defined: no counters; Eligible(c) = i_req_v[c]; o_err tied 0; response routing unchanged.

## Test plan
- Channels 0-3 all request continuously, o_req_r=1 -> o_req_sid channels in order 0,1,2,3,0 on consecutive cycles, one per cycle.
- Only channel 2 requests sid 33 ea 0x80, o_req_r=0 for 3 cycles -> o_req_v high from next cycle, sid/ea held stable until o_req_r=1, then i_req_r[2] next grant.
- Macro on, max_out=8, channel 1 requests 10 times, no responses -> exactly 8 grants, i_req_r[1] stays 0; one response sid 17 handed off -> one more grant.
- Response sid 17 with o_rsp_r[1]=0 -> o_rsp_v[1]=1, i_rsp_r=0 for next sid 20; o_rsp_r[1]=1 -> sid 20 accepted next cycle.
- Macro on, response sid 40 with channel 2 cnt=0 -> routed to o_rsp_v[2], o_err=1 and held until reset.
- Assert reset with entries in flight -> next cycle all valids 0, counters 0, rr_ptr 0, o_err 0.
